// File: rtl/id_stage.sv
// Decode stage: register file, operand read with write-through bypass, sign-extended immediate, ID/EX register (1 cycle).
// Backpressure: combinational load-use stall asks IF to hold; taken-branch flush has priority and loads a bubble.
module id_stage #(
  parameter logic [31:0] RESET_NPC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IR_if,
  input  logic [31:0] NPC_if,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [31:0] Imm,
  output logic [31:0] NPC_id,
  output logic [31:0] IR_id,
  output logic        stall
);

  localparam logic [5:0] OP_LW = 6'b100000;
  localparam logic [5:0] OP_SW = 6'b100001;

  logic [31:0] rf_q [32];

  logic [31:0] a_q, b_q, imm_q, npc_q, ir_q;
  logic [31:0] a_d, b_d, imm_d, npc_d, ir_d;

  logic [5:0]  if_op;
  logic [4:0]  if_rs, if_rt;
  logic [5:0]  id_op;
  logic [4:0]  id_rt;
  logic [31:0] rs_val, rt_val;
  logic        if_reads_rt;
  logic        hazard;

  assign if_op = IR_if[31:26];
  assign if_rs = IR_if[25:21];
  assign if_rt = IR_if[20:16];
  assign id_op = ir_q[31:26];
  assign id_rt = ir_q[20:16];

  // Write-through bypass is suppressed while reset discards the write.
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    if (if_rs != 5'd0) begin
      if (wb_en && !rst && wb_addr == if_rs) rs_val = wb_data;
      else                                   rs_val = rf_q[if_rs];
    end
    if (if_rt != 5'd0) begin
      if (wb_en && !rst && wb_addr == if_rt) rt_val = wb_data;
      else                                   rt_val = rf_q[if_rt];
    end
  end

  // Only reg-reg ALU ops and stores consume rt as a source.
  assign if_reads_rt = (if_op[5:4] == 2'b00) || (if_op == OP_SW);

  assign hazard = (id_op == OP_LW) && (id_rt != 5'd0) &&
                  ((id_rt == if_rs) || (if_reads_rt && id_rt == if_rt));
  assign stall  = hazard && !flush;

  always_comb begin
    a_d   = '0;
    b_d   = '0;
    imm_d = '0;
    npc_d = RESET_NPC;
    ir_d  = '0;
    if (!flush && !stall) begin
      a_d   = rs_val;
      b_d   = rt_val;
      imm_d = {{16{IR_if[15]}}, IR_if[15:0]};
      npc_d = NPC_if;
      ir_d  = IR_if;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wb_en && wb_addr != 5'd0) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      imm_q <= '0;
      npc_q <= RESET_NPC;
      ir_q  <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      imm_q <= imm_d;
      npc_q <= npc_d;
      ir_q  <= ir_d;
    end
  end

  assign A      = a_q;
  assign B      = b_q;
  assign Imm    = imm_q;
  assign NPC_id = npc_q;
  assign IR_id  = ir_q;

endmodule
